// File: rtl/sram_rw_hs_ext_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared constants and helpers for the masked single-port SRAM with a
// valid/ready request channel and a credit-managed response queue.
//   clog2()    : ceiling log2 used for address / counter widths
//   RL_MIN/MAX : legal range of the array read latency
//   mask_seg() : number of write-mask lanes for a given word width
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int mask_seg(input int width, input int gran);
        return width / gran;
    endfunction

endpackage

// File: rtl/sram_rw_hs_ext_if.sv
// ---------------------------------------------------------------------------
// sram_rw_hs_ext_if
// Request / response bundle of the SRAM.
//   req_valid/req_ready : request handshake
//   req_wmode           : 1 = write, 0 = read
//   req_addr/wdata/wmask: word address, write data, per-lane write enables
//   resp_valid/ready    : read response handshake
//   resp_rdata          : read data (0 while resp_valid is low)
// master = requester/consumer, slave = the memory.
// ---------------------------------------------------------------------------
interface sram_rw_hs_ext_if #(
    parameter int ADDR_W   = 8,
    parameter int WIDTH    = 32,
    parameter int MASK_SEG = 4
);
    logic                req_valid;
    logic                req_ready;
    logic                req_wmode;
    logic [ADDR_W-1:0]   req_addr;
    logic [WIDTH-1:0]    req_wdata;
    logic [MASK_SEG-1:0] req_wmask;
    logic                resp_valid;
    logic                resp_ready;
    logic [WIDTH-1:0]    resp_rdata;

    modport master (
        output req_valid, req_wmode, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wmode, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_resp_queue.sv
// ---------------------------------------------------------------------------
// sram_resp_queue
// Small flow-through FIFO holding read responses.
//   clock, reset   : clock, synchronous active-high reset (empties queue)
//   i_push_valid   : push i_push_data this cycle
//   i_pop          : consumer takes o_data this cycle (only when o_valid)
//   o_valid/o_data : head of queue; when empty a push is visible the same
//                    cycle, o_data is 0 when o_valid is low
//   o_count        : number of stored entries
// The caller guarantees no push when full (credit scheme upstream).
// ---------------------------------------------------------------------------
module sram_resp_queue
    import sram_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_push_valid,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_data,
    output logic [clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_bypass;
    logic w_store;
    logic w_take;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty  = (r_count == '0);
    // Empty queue with a simultaneous push and pop: data passes straight
    // through and nothing is stored.
    assign w_bypass = w_empty && i_push_valid && i_pop;
    assign w_store  = i_push_valid && !w_bypass;
    assign w_take   = i_pop && !w_empty;

    assign o_valid  = !w_empty || i_push_valid;
    assign o_data   = !w_empty     ? r_mem[r_rd_ptr] :
                      i_push_valid ? i_push_data     : '0;
    assign o_count  = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_take) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_take);
        end
    end
endmodule

// File: rtl/sram_rw_hs_ext.sv
// ---------------------------------------------------------------------------
// sram_rw_hs_ext
// Single-port masked SRAM with a valid/ready request channel and a
// back-pressurable read response channel.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : request/response bundle, see sram_rw_hs_ext_if
// One access per cycle. Reads return READ_LATENCY cycles after acceptance
// through a READ_LATENCY+1 deep flow-through queue; requests are throttled
// by credit = free queue entries - reads in flight, so the queue can never
// overflow. Addresses >= DEPTH drop writes and return 0 for reads.
// Memory contents survive reset.
// ---------------------------------------------------------------------------
module sram_rw_hs_ext
    import sram_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int WIDTH        = 32,
    parameter int MASK_GRAN    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    sram_rw_hs_ext_if.slave  bus
);
    localparam int ADDR_W   = clog2(DEPTH);
    localparam int MASK_SEG = mask_seg(WIDTH, MASK_GRAN);
    localparam int Q_DEPTH  = READ_LATENCY + 1;
    localparam int CRED_W   = clog2(Q_DEPTH + 1);

    if (WIDTH % MASK_GRAN != 0) begin : g_bad_mask_gran
        $error("sram_rw_hs_ext: WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_latency
        $error("sram_rw_hs_ext: READ_LATENCY out of range");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_rw_hs_ext: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic              w_pop;
    logic              w_accept;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_in_range;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_oob;
    logic              w_s1_busy;
    logic              r_rd_valid;
    logic              r_rd_oob;
    logic [WIDTH-1:0]  r_rd_data;
    logic [WIDTH-1:0]  w_push_data;
    logic              w_q_valid;
    logic [WIDTH-1:0]  w_q_data;
    logic [CRED_W-1:0] w_q_count;
    logic [CRED_W-1:0] w_inflight;
    logic [CRED_W-1:0] w_credit;

    // ---------------- request handshake and credits ----------------
    assign w_pop       = bus.resp_valid && bus.resp_ready;
    assign w_inflight  = CRED_W'(w_s1_busy) + CRED_W'(r_rd_valid);
    assign w_credit    = CRED_W'(Q_DEPTH) - w_q_count - w_inflight;
    // A pop this cycle frees an entry, so a zero credit can still accept.
    assign bus.req_ready = !reset && ((w_credit != '0) || w_pop);
    assign w_accept    = bus.req_valid && bus.req_ready;
    assign w_wr_accept = w_accept && bus.req_wmode;
    assign w_rd_accept = w_accept && !bus.req_wmode;
    assign w_in_range  = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));

    // ---------------- masked write ----------------
    always_ff @(posedge clock) begin
        if (w_wr_accept && w_in_range) begin
            for (int i = 0; i < MASK_SEG; i++) begin
                if (bus.req_wmask[i]) begin
                    r_mem[bus.req_addr][i*MASK_GRAN +: MASK_GRAN] <=
                        bus.req_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    // With latency 2 an address stage sits in front of the array read so
    // the array itself is sampled one cycle after acceptance.
    if (READ_LATENCY == 1) begin : g_rl1
        assign w_rd_en   = w_rd_accept;
        assign w_rd_addr = bus.req_addr;
        assign w_rd_oob  = !w_in_range;
        assign w_s1_busy = 1'b0;
    end else begin : g_rl2
        logic              r_s1_valid;
        logic              r_s1_oob;
        logic [ADDR_W-1:0] r_s1_addr;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_s1_valid <= 1'b0;
                r_s1_oob   <= 1'b0;
                r_s1_addr  <= '0;
            end else begin
                r_s1_valid <= w_rd_accept;
                if (w_rd_accept) begin
                    r_s1_oob  <= !w_in_range;
                    r_s1_addr <= bus.req_addr;
                end
            end
        end

        assign w_rd_en   = r_s1_valid;
        assign w_rd_addr = r_s1_addr;
        assign w_rd_oob  = r_s1_oob;
        assign w_s1_busy = r_s1_valid;
    end

    // Registered array read; kept free of reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (w_rd_en && !w_rd_oob) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_oob <= w_rd_oob;
            end
        end
    end

    assign w_push_data = r_rd_oob ? '0 : r_rd_data;

    // ---------------- response queue ----------------
    sram_resp_queue #(
        .DEPTH (Q_DEPTH),
        .WIDTH (WIDTH)
    ) u_resp_queue (
        .clock        (clock),
        .reset        (reset),
        .i_push_valid (r_rd_valid),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .o_valid      (w_q_valid),
        .o_data       (w_q_data),
        .o_count      (w_q_count)
    );

    // Responses in the pipeline during reset are hidden, then flushed.
    assign bus.resp_valid = w_q_valid && !reset;
    assign bus.resp_rdata = bus.resp_valid ? w_q_data : '0;
endmodule

// File: tb/tb_sram_rw_hs_ext.sv
// ---------------------------------------------------------------------------
// tb_sram_rw_hs_ext
// Three instances: [0] DEPTH=256 RL=1, [1] DEPTH=256 RL=2, [2] DEPTH=200 RL=1.
// Stimulus pushes expected read data (and, when the response path is free,
// the expected arrival cycle) into a per-instance scoreboard queue; a
// per-instance monitor pops and compares whenever a response is taken.
// ---------------------------------------------------------------------------
module tb_sram_rw_hs_ext;

    typedef struct {
        logic [31:0] data;
        int          due;   // expected arrival cycle, -1 = not checked
    } exp_t;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  v;
    logic [2:0]  wm;
    logic [2:0]  rr;
    logic [7:0]  ad   [3];
    logic [31:0] wd   [3];
    logic [3:0]  mk   [3];
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [31:0] rdat [3];

    exp_t sbq [3][$];
    int   nresp [3];
    int   cyc;
    int   vectors;
    int   miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_rw_hs_ext_if #(.ADDR_W(8), .WIDTH(32), .MASK_SEG(4)) bus_if [3] ();

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        assign bus_if[gi].req_valid  = v[gi];
        assign bus_if[gi].req_wmode  = wm[gi];
        assign bus_if[gi].req_addr   = ad[gi];
        assign bus_if[gi].req_wdata  = wd[gi];
        assign bus_if[gi].req_wmask  = mk[gi];
        assign bus_if[gi].resp_ready = rr[gi];
        assign rdy[gi]  = bus_if[gi].req_ready;
        assign rv[gi]   = bus_if[gi].resp_valid;
        assign rdat[gi] = bus_if[gi].resp_rdata;

        sram_rw_hs_ext #(
            .DEPTH        ((gi == 2) ? 200 : 256),
            .WIDTH        (32),
            .MASK_GRAN    (8),
            .READ_LATENCY ((gi == 1) ? 2 : 1)
        ) u_dut (
            .clock (clk),
            .reset (rst[gi]),
            .bus   (bus_if[gi])
        );

        // Scoreboard monitor: one line per response taken.
        always @(negedge clk) begin
            exp_t x;
            if (rv[gi] && rr[gi]) begin
                vectors++;
                nresp[gi]++;
                if (sbq[gi].size() == 0) begin
                    miscompares++;
                    $display("FAIL resp_%0d: unexpected response %h at cycle %0d, expected none",
                             gi, rdat[gi], cyc);
                end else begin
                    x = sbq[gi].pop_front();
                    if (rdat[gi] !== x.data || (x.due >= 0 && cyc != x.due)) begin
                        miscompares++;
                        $display("FAIL resp_%0d: got %h at cycle %0d, expected %h at cycle %0d",
                                 gi, rdat[gi], cyc, x.data, x.due);
                    end else begin
                        $display("resp inst=%0d data=%h cycle=%0d", gi, rdat[gi], cyc);
                    end
                end
            end
        end
    end

    function automatic int rl_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request on instance k; starts and ends just after a rising
    // edge. mode: 0 = no expectation, 1 = data only, 2 = data and latency.
    task automatic op(input int k, input bit is_wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      input logic [31:0] e, input int mode, output int stalls);
        bit   done;
        exp_t x;
        stalls = 0;
        done   = 1'b0;
        wm[k] = is_wr; ad[k] = a; wd[k] = d; mk[k] = m; v[k] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (rdy[k]) begin
                if (!is_wr && mode != 0) begin
                    x.data = e;
                    x.due  = (mode == 2) ? cyc + rl_of(k) : -1;
                    sbq[k].push_back(x);
                end
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL accept_%0d: request @%h not accepted after %0d cycles, expected acceptance",
                             k, a, stalls);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        v[k] = 1'b0;
    endtask

    task automatic wr(input int k, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        int s;
        op(k, 1'b1, a, d, m, 32'h0, 0, s);
        $display("write inst=%0d addr=%h data=%h mask=%h", k, a, d, m);
    endtask

    task automatic rd(input int k, input logic [7:0] a, input logic [31:0] e);
        int s;
        op(k, 1'b0, a, 32'h0, 4'h0, e, 2, s);
    endtask

    // Wait for outstanding responses, then check the idle output.
    task automatic drain(input int k);
        int n;
        n = 0;
        while (sbq[k].size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sbq[k].size() != 0) begin
            miscompares++;
            $display("FAIL drain_%0d: %0d responses outstanding, expected 0", k, sbq[k].size());
            sbq[k].delete();
        end
        @(negedge clk);
        chk($sformatf("idle_valid_%0d", k), {31'h0, rv[k]}, 32'h0);
        chk($sformatf("idle_rdata_%0d", k), rdat[k], 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int total_stalls;
        int base;
        int idx;
        int seen;
        exp_t x;

        vectors = 0; miscompares = 0;
        for (int i = 0; i < 3; i++) begin
            nresp[i] = 0; ad[i] = '0; wd[i] = '0; mk[i] = '0;
        end
        rst = 3'b111; v = 3'b000; wm = 3'b000; rr = 3'b111;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {29'h0, rv}, 32'h0);
        chk("rst_req_ready", {29'h0, rdy}, 32'h0);
        for (int i = 0; i < 3; i++) chk($sformatf("rst_rdata_%0d", i), rdat[i], 32'h0);
        @(posedge clk); #1;
        rst = 3'b000;
        @(negedge clk);
        chk("ready_after_reset", {29'h0, rdy}, 32'h7);
        @(posedge clk); #1;

        // ---------------- RL=1: write/read, masks ----------------
        wr(0, 8'h10, 32'hDEADBEEF, 4'hF);
        rd(0, 8'h10, 32'hDEADBEEF);
        wr(0, 8'h10, 32'h11223344, 4'h5);
        rd(0, 8'h10, 32'hDE22BE44);
        wr(0, 8'h10, 32'h12345678, 4'h0);
        rd(0, 8'h10, 32'hDE22BE44);
        wr(0, 8'hFF, 32'hA5A5A5A5, 4'hF);
        wr(0, 8'hFF, 32'h0000FF00, 4'h2);
        rd(0, 8'hFF, 32'hA5A5FFA5);
        rd(0, 8'h10, 32'hDE22BE44);
        drain(0);

        // ---------------- RL=2: sustained reads ----------------
        for (int a = 0; a < 256; a++) wr(1, 8'(a), pat(8'(a)), 4'hF);
        base = nresp[1];
        total_stalls = 0;
        for (int a = 0; a < 256; a++) begin
            op(1, 1'b0, 8'(a), 32'h0, 4'h0, pat(8'(a)), 2, s);
            total_stalls += s;
        end
        chk("sustained_stalls", 32'(total_stalls), 32'h0);
        drain(1);
        chk("sustained_count", 32'(nresp[1] - base), 32'd256);

        // ---------------- RL=2: back-pressure ----------------
        rr[1] = 1'b0;
        base  = nresp[1];
        idx   = 0;
        v[1] = 1'b1; wm[1] = 1'b0; ad[1] = 8'h40;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rdy[1] && idx < 5) begin
                x.data = pat(8'(8'h40 + idx)); x.due = -1;
                sbq[1].push_back(x);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 5) ad[1] = 8'(8'h40 + idx); else v[1] = 1'b0;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        @(negedge clk);
        chk("bp_ready_low", {31'h0, rdy[1]}, 32'h0);
        chk("bp_hold_valid", {31'h0, rv[1]}, 32'h1);
        chk("bp_hold_rdata", rdat[1], pat(8'h40));
        @(posedge clk); #1;
        rr[1] = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            @(negedge clk);
            if (rdy[1]) begin
                x.data = pat(8'(8'h40 + idx)); x.due = -1;
                sbq[1].push_back(x);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 5) ad[1] = 8'(8'h40 + idx); else v[1] = 1'b0;
        end
        v[1] = 1'b0;
        chk("bp_all_accepted", 32'(idx), 32'd5);
        drain(1);
        chk("bp_resp_count", 32'(nresp[1] - base), 32'd5);

        // ---------------- RL=2: reset with reads in flight ----------------
        wr(1, 8'h20, 32'hCAFEF00D, 4'hF);
        op(1, 1'b0, 8'h20, 32'h0, 4'h0, 32'h0, 0, s);
        op(1, 1'b0, 8'h21, 32'h0, 4'h0, 32'h0, 0, s);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("inflight_rst_valid", {31'h0, rv[1]}, 32'h0);
        chk("inflight_rst_ready", {31'h0, rdy[1]}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        seen = 0;
        @(negedge clk);
        chk("ready_after_reset_1", {31'h0, rdy[1]}, 32'h1);
        if (rv[1]) seen++;
        repeat (7) begin
            @(negedge clk);
            if (rv[1]) seen++;
        end
        chk("no_resp_after_reset", 32'(seen), 32'h0);
        @(posedge clk); #1;
        rd(1, 8'h20, 32'hCAFEF00D);
        rd(1, 8'h41, pat(8'h41));
        drain(1);

        // ---------------- DEPTH=200: out-of-range ----------------
        wr(2, 8'h48, 32'h48484848, 4'hF);
        wr(2, 8'h00, 32'h0BADCAFE, 4'hF);
        wr(2, 8'hC8, 32'hFFFFFFFF, 4'hF);
        rd(2, 8'hC8, 32'h00000000);
        rd(2, 8'h00, 32'h0BADCAFE);
        rd(2, 8'h48, 32'h48484848);
        wr(2, 8'hC7, 32'h13579BDF, 4'hF);
        rd(2, 8'hC7, 32'h13579BDF);
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_rw_hs_ext.md
SRAM_RW_HS_EXT -- requirements
Module: sram_rw_hs_ext

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of words, >= 2.
REQ-002 SHALL have parameter WIDTH, default 32: word width in bits.
REQ-003 SHALL have parameter MASK_GRAN, default 8: bits per write-mask lane; WIDTH a multiple of MASK_GRAN; MASK_SEG = WIDTH/MASK_GRAN.
REQ-004 SHALL have parameter READ_LATENCY, default 1: array read latency in cycles, legal 1..2.
REQ-005 SHALL have port clock  input  1: sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1: request present.
REQ-008 SHALL have port req_ready  output  1: request can be accepted.
REQ-009 SHALL have port req_wmode  input  1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_W: word address, ADDR_W = clog2(DEPTH).
REQ-011 SHALL have port req_wdata  input  WIDTH: write data.
REQ-012 SHALL have port req_wmask  input  MASK_SEG: lane i enables bits [i*MASK_GRAN +: MASK_GRAN].
REQ-013 SHALL have port resp_valid  output  1: read data present.
REQ-014 SHALL have port resp_ready  input  1: consumer takes read data.
REQ-015 SHALL have port resp_rdata  output  WIDTH: read data.

Function
REQ-016 Request SHALL be accepted in a cycle iff req_valid && req_ready; one access per cycle (single port).
REQ-017 Accepted write SHALL update only enabled lanes of word req_addr at that edge; writes produce no response.
REQ-018 Accepted read SHALL sample the array READ_LATENCY cycles after acceptance into the response queue, in acceptance order.
REQ-019 Read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-020 Response queue depth SHALL be READ_LATENCY+1; credit counter = free entries minus reads in flight.
REQ-021 req_ready SHALL be 1 iff credit > 0 or (credit == 0 and a response pops this cycle); writes SHALL also be blocked when req_ready is 0.
REQ-022 With resp_ready held 1, SHALL sustain one read per cycle indefinitely; first resp_valid exactly READ_LATENCY cycles after acceptance (queue is flow-through, zero added latency when empty).
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; pop from empty SHALL not occur; push to full SHALL not occur (guaranteed by credits).
REQ-024 resp_rdata SHALL be 0 whenever resp_valid is 0 (no garbage output).
REQ-025 resp_valid/resp_rdata SHALL hold stable while resp_valid && !resp_ready.
REQ-026 Address >= DEPTH (non-power-of-two DEPTH): write SHALL be dropped, read SHALL return 0 and still occupy a response.
REQ-027 Write with all mask lanes 0 SHALL be accepted and leave memory unchanged.

Reset
REQ-028 While reset is 1: resp_valid = 0, resp_rdata = 0, req_ready = 0, queue emptied, credit = READ_LATENCY+1.
REQ-029 Reads in flight when reset asserts SHALL be discarded and never appear at resp_*.
REQ-030 Memory contents SHALL NOT be cleared by reset; under RANDOMIZE_MEM_INIT they initialise random.
REQ-031 req_ready SHALL rise the first cycle after reset deasserts.

Structure
REQ-032 Shared package sram_pkg SHALL hold the clog2 function, READ_LATENCY min/max constants and the MASK_SEG derivation.
REQ-033 Response queue SHALL be sub-module sram_resp_queue (parametrised depth/width, flow-through, count output).
REQ-034 Elaboration SHALL fail for WIDTH % MASK_GRAN != 0 or READ_LATENCY outside 1..2.

Verification (DEPTH=256, WIDTH=32, MASK_GRAN=8)
REQ-035 RL=1: write 0xDEADBEEF @0x10 mask 0xF, read @0x10 next cycle -> resp_valid one cycle after read accept, rdata 0xDEADBEEF.
REQ-036 Write 0x11223344 mask 0x5 over 0xDEADBEEF @0x10, read -> 0xDE22BE44.
REQ-037 RL=2, resp_ready=0, issue 5 reads -> exactly 3 accepted, req_ready=0 afterwards; raise resp_ready -> 3 responses in order, then remaining reads accepted.
REQ-038 RL=2, resp_ready=1, 256 back-to-back reads -> req_ready never drops, 256 responses in address order.
REQ-039 Reset asserted with 2 reads in flight -> no resp_valid after reset; memory retains prior writes on subsequent read.
REQ-040 DEPTH=200: write @0xC8 then read @0xC8 -> rdata 0; read @0x00 unaffected.
